// File: rtl/if_stage_pkg.sv
// Shared constants and types for the instruction fetch stage.
// Defining IF_BUF2_EN widens the fetch buffer from one entry to two.
package if_stage_pkg;

    localparam logic [63:0] RESET_PC  = 64'h0000_0000_8000_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

`ifdef IF_BUF2_EN
    localparam int DEPTH = 2;
`else
    localparam int DEPTH = 1;
`endif

    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DROP = 2'd2
    } if_state_t;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/if_stage_fetch_fifo.sv
// Small circular buffer of fetched {pc, instr} pairs; the head entry feeds decode.
module fetch_fifo
    import if_stage_pkg::*;
#(
    parameter int DEPTH_P = 1,
    parameter int CNT_W_P = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               push,
    input  fetch_entry_t       push_data,
    input  logic               pop,
    output logic [CNT_W_P-1:0] count,
    output fetch_entry_t       head
);

    localparam int PTR_W = (DEPTH_P > 1) ? $clog2(DEPTH_P) : 1;

    fetch_entry_t     mem [DEPTH_P];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH_P - 1)) ? '0 : p + 1'b1;
    endfunction

    // A push into a full buffer is only legal when the head leaves in the same cycle.
    assign do_push = push && ((count < CNT_W_P'(DEPTH_P)) || pop);
    assign do_pop  = pop && (count != '0);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= bump(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= bump(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W_P'(1);
                2'b01:   count <= count - CNT_W_P'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: one outstanding memory request, buffered hand-off to decode,
// redirect flush with stale-response dropping. Buffer depth set by IF_BUF2_EN.
module if_stage
    import if_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    output logic        imem_valid_o,
    output logic [63:0] imem_addr_o,
    input  logic        imem_ready_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    input  logic        redirect_i,
    input  logic [63:0] redirect_pc_i,
    input  logic        id_ready_i,
    output logic        id_valid_o,
    output logic [63:0] pc_o,
    output logic [31:0] instr_o
);

    if_state_t          state;
    if_state_t          state_next;
    logic [63:0]        fpc;
    logic [63:0]        req_pc;
    logic [CNT_W-1:0]   count;
    fetch_entry_t       head;
    fetch_entry_t       push_entry;
    logic               req_valid;
    logic               accept;
    logic               push;
    logic               pop;
    logic               has_room;

    assign has_room     = count < CNT_W'(DEPTH);
    assign accept       = req_valid && imem_ready_i;
    assign imem_valid_o = req_valid;
    assign imem_addr_o  = fpc;

    // A redirect flushes the buffer, so any pop requested in that cycle is void.
    assign pop        = id_valid_o && id_ready_i && !redirect_i;
    assign push_entry = '{pc: req_pc, instr: imem_rdata_i};

    assign id_valid_o = !rst && (count != '0);
    assign pc_o       = id_valid_o ? head.pc : '0;
    assign instr_o    = id_valid_o ? head.instr : NOP_INSTR;

    always_comb begin
        state_next = state;
        req_valid  = 1'b0;
        push       = 1'b0;
        case (state)
            S_IDLE: begin
                req_valid = has_room && !redirect_i && !rst;
                if (req_valid && imem_ready_i) begin
                    state_next = S_REQ;
                end
            end
            S_REQ: begin
                if (imem_rvalid_i) begin
                    push       = !redirect_i;
                    state_next = S_IDLE;
                end else if (redirect_i) begin
                    state_next = S_DROP;
                end
            end
            S_DROP: begin
                if (imem_rvalid_i) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // req_pc remembers the address in flight so the response can be tagged with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            fpc    <= RESET_PC;
            req_pc <= RESET_PC;
        end else begin
            if (redirect_i) begin
                fpc <= redirect_pc_i & ~64'd3;
            end else if (accept) begin
                fpc <= fpc + 64'd4;
            end
            if (accept) begin
                req_pc <= fpc;
            end
        end
    end

    fetch_fifo #(
        .DEPTH_P (DEPTH),
        .CNT_W_P (CNT_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect_i),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .count     (count),
        .head      (head)
    );

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage with a simple instruction-memory responder.
module tb_if_stage;

    localparam logic [63:0] RESET_PC  = 64'h0000_0000_8000_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
`ifdef IF_BUF2_EN
    localparam int TB_DEPTH = 2;
`else
    localparam int TB_DEPTH = 1;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_valid_o;
    logic [63:0] imem_addr_o;
    logic        imem_ready_i = 1'b1;
    logic        imem_rvalid_i = 1'b0;
    logic [31:0] imem_rdata_i = 32'h0;
    logic        redirect_i = 1'b0;
    logic [63:0] redirect_pc_i = 64'h0;
    logic        id_ready_i = 1'b1;
    logic        id_valid_o;
    logic [63:0] pc_o;
    logic [31:0] instr_o;

    int checks = 0;
    int errors = 0;
    int resp_delay = 1;

    logic        pend = 1'b0;
    int          cnt = 0;
    logic [63:0] paddr = 64'h0;

    always #5 clk = ~clk;

    if_stage dut (
        .clk           (clk),
        .rst           (rst),
        .imem_valid_o  (imem_valid_o),
        .imem_addr_o   (imem_addr_o),
        .imem_ready_i  (imem_ready_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .id_ready_i    (id_ready_i),
        .id_valid_o    (id_valid_o),
        .pc_o          (pc_o),
        .instr_o       (instr_o)
    );

    function automatic logic [31:0] instr_of(input logic [63:0] pc);
        return pc[31:0] + 32'h1000_0000;
    endfunction

    // Memory model: answers each accepted request resp_delay cycles later.
    always @(posedge clk) begin
        if (rst) begin
            pend = 1'b0;
        end else begin
            if (imem_rvalid_i) pend = 1'b0;
            if (imem_valid_o && imem_ready_i) begin
                pend  = 1'b1;
                paddr = imem_addr_o;
                cnt   = resp_delay;
            end
        end
        #1;
        imem_rvalid_i = 1'b0;
        if (pend) begin
            cnt--;
            if (cnt <= 0) begin
                imem_rvalid_i = 1'b1;
                imem_rdata_i  = instr_of(paddr);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        imem_ready_i = 1'b1;
        redirect_i = 1'b0;
        id_ready_i = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        imem_ready_i = 1'b1;
        redirect_i = 1'b0;
        id_ready_i = 1'b1;
        tick();
        tick();
        #1;
        checks++; if (imem_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_imem_valid got %0b expected 0", imem_valid_o); end
        checks++; if (id_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_id_valid got %0b expected 0", id_valid_o); end
        checks++; if (instr_o !== NOP_INSTR) begin errors++; $display("[TB] FAIL reset_instr got %h expected %h", instr_o, NOP_INSTR); end
        checks++; if (pc_o !== 64'h0) begin errors++; $display("[TB] FAIL reset_pc got %h expected 0", pc_o); end
        rst = 1'b0;
        #1;
        checks++; if (imem_valid_o !== 1'b1) begin errors++; $display("[TB] FAIL release_imem_valid got %0b expected 1", imem_valid_o); end
        checks++; if (imem_addr_o !== RESET_PC) begin errors++; $display("[TB] FAIL release_addr got %h expected %h", imem_addr_o, RESET_PC); end
    endtask

    task automatic test_stream();
        int first_valid;
        logic [63:0] exp_addr;
        logic [63:0] exp_pc;
        first_valid = -1;
        exp_addr = RESET_PC;
        exp_pc = RESET_PC;
        resp_delay = 1;
        do_reset();
        for (int k = 0; k < 30; k++) begin
            if (imem_valid_o && imem_ready_i) begin
                checks++;
                if (imem_addr_o !== exp_addr) begin errors++; $display("[TB] FAIL stream_addr got %h expected %h", imem_addr_o, exp_addr); end
                exp_addr += 64'd4;
            end
            if (id_valid_o) begin
                if (first_valid < 0) first_valid = k;
                checks++;
                if (pc_o !== exp_pc || instr_o !== instr_of(exp_pc)) begin
                    errors++; $display("[TB] FAIL stream_out got pc %h instr %h expected pc %h instr %h", pc_o, instr_o, exp_pc, instr_of(exp_pc));
                end
                exp_pc += 64'd4;
            end else begin
                checks++;
                if (instr_o !== NOP_INSTR) begin errors++; $display("[TB] FAIL stream_nop got %h expected %h", instr_o, NOP_INSTR); end
            end
            tick();
            #1;
        end
        checks++; if (first_valid !== 2) begin errors++; $display("[TB] FAIL stream_latency got cycle %0d expected 2", first_valid); end
        checks++; if (exp_pc < RESET_PC + 64'd20) begin errors++; $display("[TB] FAIL stream_count got next pc %h expected at least %h", exp_pc, RESET_PC + 64'd20); end
    endtask

    task automatic test_stall();
        int acc;
        logic [63:0] exp_addr;
        logic [63:0] exp_pc;
        acc = 0;
        resp_delay = 1;
        do_reset();
        id_ready_i = 1'b0;
        #1;
        for (int k = 0; k < 8; k++) begin
            if (imem_valid_o && imem_ready_i) acc++;
            tick();
            #1;
        end
        checks++; if (acc !== TB_DEPTH) begin errors++; $display("[TB] FAIL stall_requests got %0d expected %0d", acc, TB_DEPTH); end
        checks++; if (imem_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL stall_full_valid got %0b expected 0", imem_valid_o); end
        checks++; if (id_valid_o !== 1'b1 || pc_o !== RESET_PC) begin errors++; $display("[TB] FAIL stall_head got valid %0b pc %h expected 1 %h", id_valid_o, pc_o, RESET_PC); end
        id_ready_i = 1'b1;
        #1;
        exp_pc = RESET_PC;
        exp_addr = RESET_PC + 64'(4 * TB_DEPTH);
        for (int k = 0; k < 20; k++) begin
            if (imem_valid_o && imem_ready_i) begin
                checks++;
                if (imem_addr_o !== exp_addr) begin errors++; $display("[TB] FAIL stall_addr got %h expected %h", imem_addr_o, exp_addr); end
                exp_addr += 64'd4;
            end
            if (id_valid_o) begin
                checks++;
                if (pc_o !== exp_pc || instr_o !== instr_of(exp_pc)) begin
                    errors++; $display("[TB] FAIL stall_out got pc %h instr %h expected pc %h", pc_o, instr_o, exp_pc);
                end
                exp_pc += 64'd4;
            end
            tick();
            #1;
        end
        checks++;
        if (exp_pc < RESET_PC + 64'(4 * (TB_DEPTH + 2))) begin errors++; $display("[TB] FAIL stall_drain got next pc %h expected at least %h", exp_pc, RESET_PC + 64'(4 * (TB_DEPTH + 2))); end
    endtask

    task automatic test_ready_stall();
        logic seen_v;
        logic seen_a;
        seen_v = 1'b0;
        seen_a = 1'b0;
        resp_delay = 1;
        do_reset();
        imem_ready_i = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (imem_valid_o !== 1'b1 || imem_addr_o !== RESET_PC) begin
                errors++; $display("[TB] FAIL ready_hold got valid %0b addr %h expected 1 %h", imem_valid_o, imem_addr_o, RESET_PC);
            end
            tick();
            #1;
        end
        imem_ready_i = 1'b1;
        #1;
        tick();
        #1;
        checks++; if (imem_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL ready_outstanding got %0b expected 0", imem_valid_o); end
        for (int k = 0; k < 10; k++) begin
            if (!seen_v && id_valid_o) begin
                seen_v = 1'b1;
                checks++;
                if (pc_o !== RESET_PC) begin errors++; $display("[TB] FAIL ready_first_pc got %h expected %h", pc_o, RESET_PC); end
            end
            if (!seen_a && imem_valid_o && imem_ready_i) begin
                seen_a = 1'b1;
                checks++;
                if (imem_addr_o !== RESET_PC + 64'd4) begin errors++; $display("[TB] FAIL ready_next_addr got %h expected %h", imem_addr_o, RESET_PC + 64'd4); end
            end
            tick();
            #1;
        end
        checks++; if (!(seen_v && seen_a)) begin errors++; $display("[TB] FAIL ready_timeout got valid %0b accept %0b expected 1 1", seen_v, seen_a); end
    endtask

    task automatic test_redirect_drop();
        logic stale;
        logic accepted;
        logic done;
        stale = 1'b0;
        accepted = 1'b0;
        done = 1'b0;
        resp_delay = 3;
        do_reset();
        tick();
        redirect_i = 1'b1;
        redirect_pc_i = 64'h0000_0000_8000_0103;
        #1;
        checks++; if (imem_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL drop_redirect_valid got %0b expected 0", imem_valid_o); end
        tick();
        redirect_i = 1'b0;
        #1;
        checks++; if (imem_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL drop_state_valid got %0b expected 0", imem_valid_o); end
        for (int k = 0; k < 20 && !done; k++) begin
            if (imem_rvalid_i && !accepted) stale = 1'b1;
            if (imem_valid_o && imem_ready_i && !accepted) begin
                accepted = 1'b1;
                checks++;
                if (imem_addr_o !== 64'h0000_0000_8000_0100 || !stale) begin
                    errors++; $display("[TB] FAIL drop_new_addr got %h after_stale %0b expected 80000100 1", imem_addr_o, stale);
                end
            end
            if (id_valid_o) begin
                done = 1'b1;
                checks++;
                if (pc_o !== 64'h0000_0000_8000_0100 || instr_o !== instr_of(64'h0000_0000_8000_0100)) begin
                    errors++; $display("[TB] FAIL drop_first_out got pc %h instr %h expected pc 80000100", pc_o, instr_o);
                end
            end
            tick();
            #1;
        end
        checks++; if (!done) begin errors++; $display("[TB] FAIL drop_timeout got no valid expected valid"); end
        resp_delay = 1;
    endtask

    task automatic test_redirect_rvalid();
        logic done;
        done = 1'b0;
        resp_delay = 1;
        do_reset();
        tick();
        redirect_i = 1'b1;
        redirect_pc_i = 64'h0000_0000_8000_0200;
        tick();
        redirect_i = 1'b0;
        #1;
        checks++; if (id_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL rvredir_id_valid got %0b expected 0", id_valid_o); end
        checks++;
        if (imem_valid_o !== 1'b1 || imem_addr_o !== 64'h0000_0000_8000_0200) begin
            errors++; $display("[TB] FAIL rvredir_req got valid %0b addr %h expected 1 80000200", imem_valid_o, imem_addr_o);
        end
        for (int k = 0; k < 10 && !done; k++) begin
            if (id_valid_o) begin
                done = 1'b1;
                checks++;
                if (pc_o !== 64'h0000_0000_8000_0200) begin errors++; $display("[TB] FAIL rvredir_first_pc got %h expected 80000200", pc_o); end
            end
            tick();
            #1;
        end
        checks++; if (!done) begin errors++; $display("[TB] FAIL rvredir_timeout got no valid expected valid"); end
    endtask

    task automatic test_redirect_flush();
        logic done;
        done = 1'b0;
        resp_delay = 1;
        do_reset();
        id_ready_i = 1'b0;
        for (int k = 0; k < 8; k++) tick();
        #1;
        checks++; if (id_valid_o !== 1'b1) begin errors++; $display("[TB] FAIL flush_prefill got %0b expected 1", id_valid_o); end
        redirect_i = 1'b1;
        redirect_pc_i = 64'h0000_0000_8000_0300;
        id_ready_i = 1'b1;
        tick();
        redirect_i = 1'b0;
        #1;
        checks++; if (id_valid_o !== 1'b0 || instr_o !== NOP_INSTR) begin errors++; $display("[TB] FAIL flush_cleared got valid %0b instr %h expected 0 %h", id_valid_o, instr_o, NOP_INSTR); end
        checks++;
        if (imem_valid_o !== 1'b1 || imem_addr_o !== 64'h0000_0000_8000_0300) begin
            errors++; $display("[TB] FAIL flush_req got valid %0b addr %h expected 1 80000300", imem_valid_o, imem_addr_o);
        end
        for (int k = 0; k < 10 && !done; k++) begin
            if (id_valid_o) begin
                done = 1'b1;
                checks++;
                if (pc_o !== 64'h0000_0000_8000_0300) begin errors++; $display("[TB] FAIL flush_first_pc got %h expected 80000300", pc_o); end
            end
            tick();
            #1;
        end
        checks++; if (!done) begin errors++; $display("[TB] FAIL flush_timeout got no valid expected valid"); end
    endtask

    task automatic test_reset_midstream();
        logic done;
        done = 1'b0;
        resp_delay = 1;
        do_reset();
        id_ready_i = 1'b0;
        for (int k = 0; k < 8; k++) tick();
        rst = 1'b1;
        #1;
        checks++; if (id_valid_o !== 1'b0 || imem_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL midrst_during got id %0b imem %0b expected 0 0", id_valid_o, imem_valid_o); end
        tick();
        rst = 1'b0;
        #1;
        checks++; if (id_valid_o !== 1'b0 || instr_o !== NOP_INSTR) begin errors++; $display("[TB] FAIL midrst_after got valid %0b instr %h expected 0 %h", id_valid_o, instr_o, NOP_INSTR); end
        checks++;
        if (imem_valid_o !== 1'b1 || imem_addr_o !== RESET_PC) begin
            errors++; $display("[TB] FAIL midrst_req got valid %0b addr %h expected 1 %h", imem_valid_o, imem_addr_o, RESET_PC);
        end
        id_ready_i = 1'b1;
        for (int k = 0; k < 10 && !done; k++) begin
            if (id_valid_o) begin
                done = 1'b1;
                checks++;
                if (pc_o !== RESET_PC) begin errors++; $display("[TB] FAIL midrst_first_pc got %h expected %h", pc_o, RESET_PC); end
            end
            tick();
            #1;
        end
        checks++; if (!done) begin errors++; $display("[TB] FAIL midrst_timeout got no valid expected valid"); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_ready_stall();
        test_redirect_drop();
        test_redirect_rvalid();
        test_redirect_flush();
        test_reset_midstream();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog got timeout expected completion");
        $fatal(1, "[TB] simulation did not complete");
    end

endmodule
